// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle for the iterative RV32M multiply/divide unit.
// The master side is the EX stage; the slave side is muldiv_unit.
interface muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_i;
   logic [2:0]            op_i;
   logic [DATA_WIDTH-1:0] src1_i;
   logic [DATA_WIDTH-1:0] src2_i;
   logic                  flush_i;
   logic                  stall_o;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] result_o;

   modport master (
      output valid_i, op_i, src1_i, src2_i, flush_i,
      input  stall_o, busy_o, done_o, result_o
   );

   modport slave (
      input  valid_i, op_i, src1_i, src2_i, flush_i,
      output stall_o, busy_o, done_o, result_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both
// run on unsigned magnitudes and the sign is fixed up when the result is
// loaded. Divide-by-zero and signed overflow are always forced to the
// architectural values.
// Optional feature macro: MULDIV_FAST_SPECIAL_EN -- when defined, special
// cases (divide by zero, signed overflow, MUL* with a zero operand) skip
// CALC and complete one cycle after acceptance.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   count_reg;
   logic [2:0]      op_reg;
   logic [W-1:0]    operand_reg;      // multiplicand or divisor magnitude
   logic [2*W-1:0]  acc_reg;          // product, or {remainder, quotient}
   logic            neg_reg;
   logic            special_reg;
   logic [W-1:0]    special_val_reg;
   logic [W-1:0]    result_reg;

   logic            stall;
   logic            accept;
   logic            last;
   logic            fast_take;

   logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
   logic [W-1:0]    a_mag, b_mag;
   logic            div_zero, overflow, mul_zero, special_in;
   logic [W-1:0]    special_val_in;

   logic [W:0]      mul_sum;
   logic [W:0]      div_shift, div_diff;
   logic            div_ge;
   logic [W-1:0]    div_rem;
   logic [2*W-1:0]  acc_step, prod_fix;
   logic [W-1:0]    lo_fix, hi_fix, calc_val, final_val;

   // Decode the incoming instruction: magnitudes, result sign and special cases
   always_comb begin
      is_div   = bus.op_i[2];
      a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                 (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
      b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
      a_neg    = a_signed && bus.src1_i[W-1];
      b_neg    = b_signed && bus.src2_i[W-1];
      a_mag    = a_neg ? (W'(0) - bus.src1_i) : bus.src1_i;
      b_mag    = b_neg ? (W'(0) - bus.src2_i) : bus.src2_i;
      // REM follows the dividend; everything else is the product of the signs
      neg_in   = (bus.op_i == 3'b110) ? a_neg : (a_neg ^ b_neg);

      div_zero = is_div && (bus.src2_i == '0);
      overflow = ((bus.op_i == 3'b100) || (bus.op_i == 3'b110)) &&
                 (bus.src1_i == MIN_NEG) && (bus.src2_i == '1);
      mul_zero = !is_div && ((bus.src1_i == '0) || (bus.src2_i == '0));
      special_in     = div_zero || overflow || mul_zero;
      special_val_in = '0;
      if (div_zero)
         special_val_in = bus.op_i[1] ? bus.src1_i : '1;
      else if (overflow)
         special_val_in = bus.op_i[1] ? '0 : MIN_NEG;
   end

`ifdef MULDIV_FAST_SPECIAL_EN
   assign fast_take = special_in;
`else
   assign fast_take = 1'b0;
`endif

   assign accept = (state_reg == IDLE) && bus.valid_i && !bus.flush_i;
   assign last   = (count_reg == CW'(W - 1));

   // One shift-add or shift-subtract step, plus sign correction of the outcome
   always_comb begin
      mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
      div_shift = acc_reg[2*W-1:W-1];
      div_diff  = div_shift - {1'b0, operand_reg};
      div_ge    = (div_shift >= {1'b0, operand_reg});
      div_rem   = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      acc_step  = op_reg[2] ? {div_rem, acc_reg[W-2:0], div_ge}
                            : {mul_sum, acc_reg[W-1:1]};

      prod_fix  = neg_reg ? ((2*W)'(0) - acc_step) : acc_step;
      lo_fix    = neg_reg ? (W'(0) - acc_step[W-1:0]) : acc_step[W-1:0];
      hi_fix    = neg_reg ? (W'(0) - acc_step[2*W-1:W]) : acc_step[2*W-1:W];
      case (op_reg)
         3'b000:                 calc_val = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011: calc_val = prod_fix[2*W-1:W];
         3'b100, 3'b101:         calc_val = lo_fix;
         default:                calc_val = hi_fix;
      endcase
      final_val = special_reg ? special_val_reg : calc_val;
   end

   // Next-state and stall request; flush overrides everything
   always_comb begin
      state_next = state_reg;
      stall      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.valid_i && !bus.flush_i) begin
               stall      = 1'b1;
               state_next = fast_take ? DONE : CALC;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (last)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.flush_i)
         state_next = IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Operand capture, iteration and result load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg       <= '0;
         op_reg          <= '0;
         operand_reg     <= '0;
         acc_reg         <= '0;
         neg_reg         <= 1'b0;
         special_reg     <= 1'b0;
         special_val_reg <= '0;
         result_reg      <= '0;
      end else if (accept) begin
         count_reg       <= '0;
         op_reg          <= bus.op_i;
         operand_reg     <= is_div ? b_mag : a_mag;
         acc_reg         <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
         neg_reg         <= neg_in;
         special_reg     <= special_in;
         special_val_reg <= special_val_in;
         if (fast_take)
            result_reg <= special_val_in;
      end else if ((state_reg == CALC) && !bus.flush_i) begin
         acc_reg   <= acc_step;
         count_reg <= count_reg + CW'(1);
         if (last)
            result_reg <= final_val;
      end
   end

   assign bus.stall_o  = stall;
   assign bus.busy_o   = (state_reg != IDLE);
   assign bus.done_o   = (state_reg == DONE);
   assign bus.result_o = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed vectors, latency and
// stall-length checks, flush, mid-operation reset and ignored valid pulses.
module tb_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

   muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Caller is positioned just after a rising edge with the unit idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input bit special, input bit pulse);
      int          done_at   = -1;
      int          stall_cnt = 0;
      int          exp_lat;
      logic [31:0] res = '0;
      exp_lat = (FAST && special) ? 1 : 33;
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.src1_i  = a;
      bus.src2_i  = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.stall_o) stall_cnt++;
         if (bus.done_o) begin
            done_at = i;
            res     = bus.result_o;
         end
         @(posedge clk);
         #1;
         bus.valid_i = pulse && ((i + 1 == 5) || (i + 1 == exp_lat));
         if (pulse) bus.src1_i = ~a;
         if (done_at >= 0) break;
      end
      bus.valid_i = 1'b0;
      check_value({tag, "_result"}, res, exp);
      check_value({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
      check_value({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
      $display("op=%0d a=0x%08h b=0x%08h result=0x%08h done_at=%0d stall=%0d [%s]",
               op, a, b, res, done_at, stall_cnt, tag);
   endtask

   initial begin
      int extra_done;
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.op_i    = 3'b000;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      bus.flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_stall", 32'(bus.stall_o), 32'd0);
      check_value("rst_busy", 32'(bus.busy_o), 32'd0);
      check_value("rst_done", 32'(bus.done_o), 32'd0);
      check_value("rst_result", bus.result_o, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul_7_m3",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("mulhu_m1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("mulh_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("mulhu_2p33",  3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0, 1'b0);
      run_op("mul_zero",    3'b000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
      run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0);
      run_op("remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0);
      run_op("div_5_0",     3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("rem_5_0",     3'b110, 32'd5,         32'd0,         32'd5,         1'b1, 1'b0);
      run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
      run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      run_op("divu_m1_0",   3'b101, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("remu_7_0",    3'b111, 32'd7,         32'd0,         32'd7,         1'b1, 1'b0);

      // Flush at iteration 10 of DIVU 100/7: prior result 7 must survive
      bus.valid_i = 1'b1;
      bus.op_i    = 3'b101;
      bus.src1_i  = 32'd100;
      bus.src2_i  = 32'd7;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(negedge clk);
      check_value("flush_calc_stall", 32'(bus.stall_o), 32'd1);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      check_value("flush_busy", 32'(bus.busy_o), 32'd0);
      check_value("flush_done", 32'(bus.done_o), 32'd0);
      check_value("flush_result_held", bus.result_o, 32'd7);
      $display("flush during divu: busy=%0d result=0x%08h", bus.busy_o, bus.result_o);
      run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

      // Flush together with valid in IDLE: not accepted
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.op_i    = 3'b000;
      @(negedge clk);
      check_value("flush_accept_stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      check_value("flush_accept_busy", 32'(bus.busy_o), 32'd0);
      $display("flush with valid in idle: busy=%0d", bus.busy_o);

      // Reset during CALC of DIV
      bus.valid_i = 1'b1;
      bus.op_i    = 3'b100;
      bus.src1_i  = 32'hFFFF_FFF9;
      bus.src2_i  = 32'd2;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_value("pre_rst_busy", 32'(bus.busy_o), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_value("midrst_busy", 32'(bus.busy_o), 32'd0);
      check_value("midrst_stall", 32'(bus.stall_o), 32'd0);
      check_value("midrst_done", 32'(bus.done_o), 32'd0);
      check_value("midrst_result", bus.result_o, 32'd0);
      $display("reset during div: busy=%0d result=0x%08h", bus.busy_o, bus.result_o);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // valid pulsed in CALC and DONE (with a changed src1) is ignored
      run_op("divu_pulsed", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      extra_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done_o) extra_done++;
      end
      check_value("pulse_extra_done", 32'(extra_done), 32'd0);
      check_value("pulse_idle_busy", 32'(bus.busy_o), 32'd0);
      $display("after pulsed op: extra_done=%0d", extra_done);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the EX operand-select logic. It consumes the forwarded register operands and the M-extension funct3. It holds the pipeline with a stall request while it iterates, then presents a registered 32-bit result for one cycle. The result goes to the EX/MEM register in place of the ALU result.

## Interface
- `DATA_WIDTH`, 32: operand/result width; iteration count equals `DATA_WIDTH`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `valid_i` input 1: an M-extension instruction is in EX with operands ready.
- `op_i` input 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1_i` input DATA_WIDTH: forwarded rs1 value (dividend / multiplicand).
- `src2_i` input DATA_WIDTH: forwarded rs2 value (divisor / multiplier).
- `flush_i` input 1: branch/exception flush; aborts any operation in flight.
- `stall_o` output 1: freeze PC, IF/ID and ID/EX while high.
- `busy_o` output 1: state is not IDLE.
- `done_o` output 1: one-cycle pulse; `result_o` valid for the pipeline to capture.
- `result_o` output DATA_WIDTH: registered result, held until the next completion.

## Operation
- States: IDLE, CALC, DONE. Reset or flush forces IDLE.
- IDLE: when `valid_i`=1, latch `op_i`, operand magnitudes and the result sign, and clear the iteration counter.
  - Next state is CALC, or DONE for a special case when `MULDIV_FAST_SPECIAL_EN` is defined.
- CALC: one iteration per cycle.
  - Multiply: radix-2 shift-add into a 2×DATA_WIDTH product register.
  - Divide: restoring shift-subtract, yielding DATA_WIDTH quotient and remainder.
  - After iteration `DATA_WIDTH`, go to DONE. In the same edge, load `result_o` with the selected field, sign-corrected.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU and REMU: both unsigned.
  - DIV: quotient is negative iff the operand signs differ.
  - REM: remainder takes the sign of the dividend.
- Result selection: MUL takes the low half of the product; MULH, MULHSU and MULHU take the high half.
- Special cases, which always override the iterative result:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `src1_i`.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- `valid_i` outside IDLE is ignored. Operands are sampled only at acceptance.
- `flush_i` has priority over `valid_i` and state progression. Any state goes to IDLE next edge, no `done_o`, and `result_o` is unchanged.
- The EX stage holds `valid_i` low in the cycle after `done_o`, because ID/EX advances during DONE. An assertion in that cycle starts a new operation.

## Timing
- Reset values: `stall_o`=0, `busy_o`=0, `done_o`=0, `result_o`=0. Counter and state are cleared.
- `stall_o` is combinational: `(state==IDLE && valid_i && !flush_i) || state==CALC`. It is low in DONE so the pipeline advances and captures `result_o`.
- Normal latency: accept on edge E0. Iterations occur on E1..E32, with the result loaded on E32. `done_o` is high in the cycle after E32. IDLE is reached on E33.
  - The instruction occupies EX for 33 cycles of stall plus 1 DONE cycle.
- Fast-path latency with the macro: accept on E0 with the result loaded on E0. `done_o` is high in the next cycle. Stall is 1 cycle.
- `rst_n` low mid-CALC: next edge goes to IDLE and all outputs take their reset values.
- Simultaneous `flush_i` and acceptance in IDLE: the operation is not accepted and `stall_o` stays 0.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined:
  - Divide-by-zero, signed overflow, and MUL* with either operand 0 bypass CALC (IDLE → DONE).
- Not defined:
  - Every operation takes the full `DATA_WIDTH` iterations.
  - Special-case results are still forced when the result is loaded on the final iteration, so results are identical either way.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result_o`=0xFFFFFFEB. `done_o` rises 33 cycles after acceptance; `stall_o` is high for 33 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0.
  - `done_o` arrives 1 cycle after acceptance with the macro, 33 cycles without it.
- DIVU 100 / 7 with `flush_i` at iteration 10 → IDLE next edge, no `done_o`, `result_o` keeps its prior value. A new MUL 3 × 4 accepted the next cycle → 12.
- `rst_n` low during CALC of DIV → outputs 0 next edge. `valid_i` pulsed during CALC or DONE is ignored with no second `done_o`.
